// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaler, free-running/auto-reload counter, compare match
// and a level interrupt behind a single-cycle-ready bus slave.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0300_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic [2:0]    ctrl;      // {irq_en, autoreload, en}
  logic [PW-1:0] prescale;
  logic [DW-1:0] compare;
  logic [DW-1:0] count;
  logic          match;
  logic [PW-1:0] pcnt;

  logic [2:0]    ctrl_next;
  logic [PW-1:0] prescale_next;
  logic [DW-1:0] compare_next;
  logic [DW-1:0] count_next;
  logic          match_next;
  logic [PW-1:0] pcnt_next;

  logic          sel;
  logic [2:0]    off;
  logic          wr;
  logic          wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic          tick;
  logic          hit;
  logic          ready_next;
  logic [DW-1:0] rd_mux;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[1:0];

  function automatic logic [DW-1:0] merge32(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [3:0]    strb);
    logic [DW-1:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  // Decode; a write commits only on the edge that ends the ready cycle
  always_comb begin
    sel         = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    off         = mem_addr[4:2];
    wr          = mem_ready && sel && (mem_wstrb != 4'b0000);
    wr_ctrl     = wr && (off == OFF_CTRL);
    wr_prescale = wr && (off == OFF_PRESCALE);
    wr_compare  = wr && (off == OFF_COMPARE);
    wr_count    = wr && (off == OFF_COUNT);
    wr_status   = wr && (off == OFF_STATUS);
    ready_next  = sel && !mem_ready;
    tick        = ctrl[0] && (pcnt == prescale);
    hit         = (count == compare);
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:     rd_mux = {29'd0, ctrl};
      OFF_PRESCALE: rd_mux = {16'd0, prescale};
      OFF_COMPARE:  rd_mux = compare;
      OFF_COUNT:    rd_mux = count;
      OFF_STATUS:   rd_mux = {31'd0, match};
      default:      rd_mux = '0;
    endcase
  end

  // Register next-state; a bus write to COUNT pre-empts the tick and its match check
  always_comb begin
    ctrl_next     = ctrl;
    prescale_next = prescale;
    compare_next  = compare;
    count_next    = count;
    match_next    = match;
    pcnt_next     = pcnt;

    if (wr_ctrl && mem_wstrb[0])
      ctrl_next = mem_wdata[2:0];

    if (wr_prescale) begin
      prescale_next[7:0]  = mem_wstrb[0] ? mem_wdata[7:0]  : prescale[7:0];
      prescale_next[15:8] = mem_wstrb[1] ? mem_wdata[15:8] : prescale[15:8];
    end

    if (wr_compare)
      compare_next = merge32(compare, mem_wdata, mem_wstrb);

    if (!ctrl[0])
      pcnt_next = '0;
    else if (wr_prescale || tick)
      pcnt_next = '0;
    else
      pcnt_next = pcnt + PW'(1);

    if (wr_count)
      count_next = merge32(count, mem_wdata, mem_wstrb);
    else if (tick)
      count_next = (hit && ctrl[1]) ? '0 : count + DW'(1);

    if (tick && !wr_count && hit)
      match_next = 1'b1;
    else if (wr_status && mem_wstrb[0] && mem_wdata[0])
      match_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      prescale  <= PRESCALE_RST;
      compare   <= '1;
      count     <= '0;
      match     <= 1'b0;
      pcnt      <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      ctrl      <= ctrl_next;
      prescale  <= prescale_next;
      compare   <= compare_next;
      count     <= count_next;
      match     <= match_next;
      pcnt      <= pcnt_next;
      mem_ready <= ready_next;
      mem_rdata <= ready_next ? rd_mux : '0;
    end
  end

  assign irq = match && ctrl[2];

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: register access, prescaler/counter,
// match/autoreload, collisions, decode and reset abort.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] A_CTRL  = 32'h0300_0000;
  localparam logic [31:0] A_PRE   = 32'h0300_0004;
  localparam logic [31:0] A_CMP   = 32'h0300_0008;
  localparam logic [31:0] A_CNT   = 32'h0300_000C;
  localparam logic [31:0] A_STAT  = 32'h0300_0010;

  always #5 clk = ~clk;

  bus_timer dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .irq       (irq)
  );

  // One bus transaction; lat = cycles from valid to ready, -1 if none within 8 cycles.
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int lat);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = i;
        rd  = mem_rdata;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] d;
    int l;
    bus(a, wd, ws, d, l);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    int l;
    rst = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = A_CMP;
    mem_wdata = 32'h0;
    mem_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, want 0/0/0", mem_ready, mem_rdata, irq);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    rst = 1'b0;
    @(posedge clk); #1;

    bus(A_PRE, 32'h0, 4'h0, d, l);
    n_tests++;
    if (l !== 1 || d !== 32'h0000_0018) begin
      n_fail++;
      $display("FAIL reset_prescale: lat=%0d rdata=%h, want 1/00000018", l, d);
    end
    bus(A_CMP, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_compare: got %h want ffffffff", d);
    end
    bus(A_CTRL, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h want 0", d);
    end
    bus(A_CNT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_count: got %h want 0", d);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] d;
    int l;
    wr(A_CMP, 32'h1122_3344, 4'hF);
    wr(A_CMP, 32'hAABB_CCDD, 4'b0010);
    bus(A_CMP, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h1122_CC44) begin
      n_fail++;
      $display("FAIL byte_strobe: got %h want 1122cc44", d);
    end
    bus(32'h0300_000B, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h1122_CC44) begin
      n_fail++;
      $display("FAIL addr_lsb_ignored: got %h want 1122cc44", d);
    end
    wr(A_PRE, 32'hFFFF_0005, 4'hF);
    bus(A_PRE, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL prescale_upper_zero: got %h want 00000005", d);
    end
  endtask

  task automatic test_autoreload;
    logic [31:0] d;
    int l;
    logic [31:0] exp_c [4];
    logic        exp_i [4];
    exp_c = '{32'd1, 32'd2, 32'd3, 32'd0};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b1};
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_CMP, 32'd3, 4'hF);
    wr(A_CTRL, 32'd7, 4'hF);
    n_tests++;
    if (dut.count !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_start: count=%0d irq=%b, want 0/0", dut.count, irq);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut.count !== exp_c[i] || irq !== exp_i[i]) begin
        n_fail++;
        $display("FAIL ar_step%0d: count=%0d irq=%b, want %0d/%b", i, dut.count, irq, exp_c[i], exp_i[i]);
      end
    end
    wr(A_STAT, 32'd1, 4'hF);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_clear: irq=%b want 0", irq);
    end
    // This clear lands on the edge where COUNT==3 matches again
    wr(A_STAT, 32'd1, 4'hF);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_match: irq=%b want 1", irq);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    bus(A_CNT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL ar_stop_count: got %0d want 2", d);
    end
    bus(A_STAT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL ar_status: got %h want 1", d);
    end
    wr(A_STAT, 32'd1, 4'hF);
    bus(A_STAT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL status_w1c: got %h want 0", d);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    int l;
    wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    @(posedge clk); #1;
    n_tests++;
    if (dut.count !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_count: got %h want 0", dut.count);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    bus(A_CNT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL wrap_after: got %0d want 2", d);
    end
    bus(A_STAT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_status: got %h want 0", d);
    end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    int l;
    wr(A_CTRL, 32'd1, 4'hF);
    wr(A_CNT, 32'd100, 4'hF);
    n_tests++;
    if (dut.count !== 32'd100) begin
      n_fail++;
      $display("FAIL count_write_vs_tick: got %0d want 100", dut.count);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    bus(A_CNT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd102) begin
      n_fail++;
      $display("FAIL collision_after: got %0d want 102", d);
    end
  endtask

  task automatic test_prescale;
    logic [31:0] d;
    int l;
    wr(A_PRE, 32'd3, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (dut.count !== 32'd0) begin
      n_fail++;
      $display("FAIL presc_early: count=%0d want 0", dut.count);
    end
    @(posedge clk); #1;
    n_tests++;
    if (dut.count !== 32'd1) begin
      n_fail++;
      $display("FAIL presc_first_tick: count=%0d want 1", dut.count);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    bus(A_CNT, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL presc_hold: got %0d want 1", d);
    end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    int l;
    bus(32'h0200_0000, 32'h0, 4'h0, d, l);
    n_tests++;
    if (l !== -1) begin
      n_fail++;
      $display("FAIL decode_miss_read: lat=%0d want none", l);
    end
    bus(32'h0200_0008, 32'h0, 4'hF, d, l);
    n_tests++;
    if (l !== -1) begin
      n_fail++;
      $display("FAIL decode_miss_write: lat=%0d want none", l);
    end
    bus(A_CMP, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'd5) begin
      n_fail++;
      $display("FAIL decode_miss_effect: compare=%h want 5", d);
    end
    wr(32'h0300_0018, 32'hFFFF_FFFF, 4'hF);
    bus(32'h0300_0018, 32'h0, 4'h0, d, l);
    n_tests++;
    if (l !== 1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL reserved_read: lat=%0d rdata=%h, want 1/0", l, d);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] d;
    int l;
    mem_addr  = A_CMP;
    mem_wdata = 32'h0000_1234;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: ready=%b want 0", mem_ready);
    end
    rst = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    bus(A_CMP, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL abort_no_write: compare=%h want ffffffff", d);
    end

    mem_addr  = A_CMP;
    mem_wdata = 32'h0000_5678;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (mem_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL held_rst_ready%0d: ready=%b want 0", i, mem_ready);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_ready: ready=%b want 1", mem_ready);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    bus(A_CMP, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h0000_5678) begin
      n_fail++;
      $display("FAIL post_rst_write: compare=%h want 00005678", d);
    end
    bus(A_PRE, 32'h0, 4'h0, d, l);
    n_tests++;
    if (d !== 32'h0000_0018) begin
      n_fail++;
      $display("FAIL post_rst_prescale: got %h want 00000018", d);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    test_reset;
    test_strobes;
    test_autoreload;
    test_wrap;
    test_collision;
    test_prescale;
    test_decode;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0300_0000: base of the 32-byte register window; must be 32-byte aligned.
REQ-002 Parameter PRESCALE_RST, default 16'd24: reset value of PRESCALE, giving 1 us ticks at 25 MHz.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port mem_valid, input, 1: initiator request valid; held high until mem_ready is seen.
REQ-006 Port mem_addr, input, 32: byte address of the request.
REQ-007 Port mem_wdata, input, 32: write data.
REQ-008 Port mem_wstrb, input, 4: byte write strobes; 4'b0000 means a read.
REQ-009 Port mem_ready, output, 1: one-cycle completion pulse.
REQ-010 Port mem_rdata, output, 32: read data, valid while mem_ready=1 and 0 otherwise.
REQ-011 Port irq, output, 1: level interrupt, equal to STATUS.match AND CTRL.irq_en.

Function
REQ-012 sel SHALL be mem_valid AND (mem_addr[31:5] == BASE_ADDR[31:5]); no other requests are answered.
REQ-013 Handshake: mem_ready SHALL rise in the cycle after sel first goes high, last exactly one cycle, and stay 0 for the cycle following it (mem_ready_next = sel AND NOT mem_ready).
REQ-014 Each transaction SHALL take effect exactly once, in the cycle mem_ready=1: write committed at that clock edge, mem_rdata driven during it.
REQ-015 Register map (offset = mem_addr[4:2]):
- 0x00 CTRL: bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0.
- 0x04 PRESCALE: bits 15:0; upper bits read 0.
- 0x08 COMPARE: 32 bits.
- 0x0C COUNT: 32 bits.
- 0x10 STATUS: bit0 match; write 1 to clear.
REQ-016 Writes SHALL honour mem_wstrb per byte; unstrobed bytes are kept.
REQ-017 Offsets 0x14-0x1C SHALL read 0, ignore writes, and still assert mem_ready.
REQ-018 mem_addr[1:0] SHALL be ignored.
REQ-019 Prescaler: 16-bit pcnt increments while en=1; when pcnt == PRESCALE it SHALL return to 0 and produce a one-cycle tick.
- PRESCALE=0 gives a tick every enabled cycle.
REQ-020 On tick, COUNT SHALL increment by 1 modulo 2^32; 32'hFFFF_FFFF wraps to 0 with no flag.
REQ-021 Match: on a tick where the pre-increment COUNT equals COMPARE, STATUS.match SHALL set.
- With autoreload=1, COUNT becomes 0 instead of incrementing.
- With autoreload=0, COUNT increments normally.
REQ-022 While en=0: pcnt SHALL be held at 0, COUNT held, and no tick issued.
- Setting en from 0 to 1 gives the first tick PRESCALE+1 cycles later.
REQ-023 Simultaneous bus write to COUNT and a tick: the bus value SHALL win, with no increment and no match evaluation that cycle.
REQ-024 Simultaneous STATUS write-1-clear and a match: match SHALL remain set.
REQ-025 A write to PRESCALE SHALL also clear pcnt to 0.
REQ-026 irq SHALL follow STATUS.match and irq_en combinationally from registers, with no additional latency.

Reset
REQ-027 While rst=1, the following SHALL hold at the next edge:
- mem_ready=0, mem_rdata=0, irq=0.
- CTRL=0, PRESCALE=PRESCALE_RST, COMPARE=32'hFFFF_FFFF, COUNT=0, STATUS=0, pcnt=0.
REQ-028 rst asserted mid-transaction SHALL abort it: no write is committed and no mem_ready is issued.
- After rst falls with mem_valid still high, the transaction SHALL be answered normally per REQ-013.
REQ-029 rst SHALL override every bus access and tick in the same cycle.

Verification
REQ-030 Read after reset: read 0x0300_0004 -> mem_ready exactly 1 cycle after valid, rdata=32'h0000_0018; read 0x0300_0008 -> 32'hFFFF_FFFF.
REQ-031 Byte strobes: COMPARE=32'h1122_3344, then write wdata=32'hAABB_CCDD with wstrb=4'b0010 -> COMPARE reads 32'h1122_CC44.
REQ-032 Autoreload: PRESCALE=0, COMPARE=3, CTRL=3'b111 -> COUNT runs 0,1,2,3,0, with match and irq set on the 3->0 tick; write STATUS=1 -> irq=0 next cycle.
REQ-033 Wrap: COUNT=32'hFFFF_FFFF, COMPARE=5, autoreload=0, en=1 -> COUNT=0 after the next tick, STATUS=0.
REQ-034 Collision: bus write COUNT=100 in the same cycle as a tick -> COUNT=100, not 101.
- STATUS clear coinciding with a match -> match stays 1.
REQ-035 Decode and reset:
- Access to 0x0200_0000 -> mem_ready never asserted.
- Access to offset 0x18 -> rdata=0 with a ready pulse.
- rst pulse during a pending write -> register unchanged.
